// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the audio sample playback path.
//   sample_t          - one Q1.14 two's complement audio sample
//   streamer_state_t  - playback FSM states of rom_sample_streamer
//   N_SAMPLES_*       - sample counts of the stored clips
//   SAMPLE_DIV_16K    - clk cycles per sample period at 50 MHz / 16 kHz
package audio_pkg;

  typedef logic [15:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TICK = 2'd1,
    ST_FETCH     = 2'd2,
    ST_DONE      = 2'd3
  } streamer_state_t;

  localparam int N_SAMPLES_4S   = 64000;
  localparam int N_SAMPLES_7S   = 112000;
  localparam int SAMPLE_DIV_16K = 3125;

endpackage

// File: rtl/sample_tick_div.sv
// sample_tick_div: sample-rate divider. Counts 0..DIV-1 while enabled and
// wraps; tick is high in the cycle the count equals DIV-1.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   clear in  synchronous return of the count to 0 (has priority over en)
//   en    in  count enable; the count holds while low
//   tick  out one-cycle pulse at the end of each sample period
module sample_tick_div #(
  parameter int DIV = 3125
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int            CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;

  // Divider count register: clear first, then wrap at DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear) begin
      cnt_r <= {CW{1'b0}};
    end else if (en) begin
      if (cnt_r == LAST) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1'b1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Tick is a pure decode of the count register, so it is glitch-free.
  assign tick = en && (cnt_r == LAST);

endmodule

// File: rtl/rom_sample_streamer.sv
// rom_sample_streamer: paces reads of the single-port sample ROM at the audio
// sample rate, absorbs the ROM's one-cycle read latency and presents each
// Q1.14 sample on a valid/ready stream.
// Ports:
//   clk          in  system clock
//   rst_n        in  asynchronous active-low reset
//   start        in  pulse: begin playback from sample 0 (ignored while busy)
//   stop         in  pulse: abort playback, discard pending sample (wins over start)
//   rom_addr     out byte address to the ROM, {index, 2'b00} zero-extended
//   rom_rd       in  ROM read data, valid one cycle after rom_addr is sampled
//   sample_out   out current sample, passed through unmodified
//   sample_valid out sample_out holds an unconsumed sample
//   sample_ready in  consumer accepts the sample when high with sample_valid
//   busy         out high in WAIT_TICK and FETCH
//   done         out sticky end of non-looping playback, cleared by start
//   overrun      out sticky dropped sample tick, cleared by start
module rom_sample_streamer
  import audio_pkg::*;
#(
  parameter int   N_SAMPLES  = 64000,
  parameter int   SAMPLE_DIV = 3125,
  parameter logic LOOP       = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  output logic [31:0] rom_addr,
  input  logic [15:0] rom_rd,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam int               IDX_W    = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

  streamer_state_t  state_r;
  streamer_state_t  state_nxt_s;
  logic [IDX_W-1:0] index_r;
  sample_t          sample_r;
  logic             valid_r;
  logic             busy_r;
  logic             done_r;
  logic             overrun_r;

  logic tick_s;
  logic div_en_s;
  logic div_clear_s;
  logic consume_s;
  logic slot_free_s;
  logic start_play_s;
  logic stop_act_s;
  logic fetch_s;
  logic drop_s;

  assign consume_s   = valid_r && sample_ready;
  // The slot is free if empty, or if the held sample leaves at this same edge.
  assign slot_free_s = !valid_r || consume_s;
  assign div_en_s    = (state_r == ST_WAIT_TICK) || (state_r == ST_FETCH);
  assign div_clear_s = start_play_s || stop_act_s;

  sample_tick_div #(
    .DIV (SAMPLE_DIV)
  ) u_tick_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (div_clear_s),
    .en    (div_en_s),
    .tick  (tick_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state and per-cycle control strobes; stop always wins.
  always_comb begin
    state_nxt_s  = state_r;
    start_play_s = 1'b0;
    stop_act_s   = 1'b0;
    fetch_s      = 1'b0;
    drop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // stop has nothing to abort here; start together with stop is dropped.
        if (start && !stop) begin
          state_nxt_s  = ST_WAIT_TICK;
          start_play_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_TICK: begin
        if (stop) begin
          state_nxt_s = ST_IDLE;
          stop_act_s  = 1'b1;
        end else if (tick_s) begin
          if (slot_free_s) begin
            state_nxt_s = ST_FETCH;
          end else begin
            state_nxt_s = ST_WAIT_TICK;
            drop_s      = 1'b1;
          end
        end else begin
          state_nxt_s = ST_WAIT_TICK;
        end
      end
      ST_FETCH: begin
        if (stop) begin
          state_nxt_s = ST_IDLE;
          stop_act_s  = 1'b1;
        end else begin
          fetch_s = 1'b1;
          if ((index_r == LAST_IDX) && (LOOP == 1'b0)) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_WAIT_TICK;
          end
        end
      end
      ST_DONE: begin
        if (stop) begin
          state_nxt_s = ST_IDLE;
          stop_act_s  = 1'b1;
        end else if (start) begin
          state_nxt_s  = ST_WAIT_TICK;
          start_play_s = 1'b1;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Sample index: advances only at the end of FETCH, so rom_addr is stable
  // across the ROM's sampling edge. At the end of a non-looping clip it holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_r <= {IDX_W{1'b0}};
    end else if (stop_act_s || start_play_s) begin
      index_r <= {IDX_W{1'b0}};
    end else if (fetch_s) begin
      if (index_r == LAST_IDX) begin
        index_r <= (LOOP == 1'b1) ? {IDX_W{1'b0}} : index_r;
      end else begin
        index_r <= index_r + IDX_W'(1'b1);
      end
    end else begin
      index_r <= index_r;
    end
  end

  // Output slot: a FETCH reload overrides a same-cycle consumption.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_r <= 16'h0000;
      valid_r  <= 1'b0;
    end else if (stop_act_s) begin
      sample_r <= sample_r;
      valid_r  <= 1'b0;
    end else if (fetch_s) begin
      sample_r <= rom_rd;
      valid_r  <= 1'b1;
    end else if (consume_s) begin
      sample_r <= sample_r;
      valid_r  <= 1'b0;
    end else begin
      sample_r <= sample_r;
      valid_r  <= valid_r;
    end
  end

  // Sticky status flags, both cleared when playback (re)starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else if (start_play_s) begin
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      done_r    <= done_r || (fetch_s && (state_nxt_s == ST_DONE));
      overrun_r <= overrun_r || drop_s;
    end
  end

  // Busy is registered from the next state so it lines up with state_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s == ST_WAIT_TICK) || (state_nxt_s == ST_FETCH);
    end
  end

  assign rom_addr     = 32'({index_r, 2'b00});
  assign sample_out   = sample_r;
  assign sample_valid = valid_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign overrun      = overrun_r;

endmodule

// File: tb/tb_rom_sample_streamer.sv
// tb_rom_sample_streamer: directed bench for rom_sample_streamer with
// SAMPLE_DIV = 4 and N_SAMPLES = 8. Two instances (LOOP = 0 and LOOP = 1)
// each read a registered ROM model holding rom[i] = i.
module tb_rom_sample_streamer;

  logic        clk;
  logic        rst_n;

  logic        start_nl, stop_nl, ready_nl;
  logic [31:0] addr_nl;
  logic [15:0] rd_nl, out_nl;
  logic        valid_nl, busy_nl, done_nl, ovr_nl;

  logic        start_lp, stop_lp, ready_lp;
  logic [31:0] addr_lp;
  logic [15:0] rd_lp, out_lp;
  logic        valid_lp, busy_lp, done_lp, ovr_lp;

  int n_checks = 0;
  int n_fail   = 0;

  rom_sample_streamer #(.N_SAMPLES(8), .SAMPLE_DIV(4), .LOOP(1'b0)) dut_nl (
    .clk(clk), .rst_n(rst_n), .start(start_nl), .stop(stop_nl),
    .rom_addr(addr_nl), .rom_rd(rd_nl), .sample_out(out_nl),
    .sample_valid(valid_nl), .sample_ready(ready_nl),
    .busy(busy_nl), .done(done_nl), .overrun(ovr_nl)
  );

  rom_sample_streamer #(.N_SAMPLES(8), .SAMPLE_DIV(4), .LOOP(1'b1)) dut_lp (
    .clk(clk), .rst_n(rst_n), .start(start_lp), .stop(stop_lp),
    .rom_addr(addr_lp), .rom_rd(rd_lp), .sample_out(out_lp),
    .sample_valid(valid_lp), .sample_ready(ready_lp),
    .busy(busy_lp), .done(done_lp), .overrun(ovr_lp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered ROM models, rom[i] = i.
  always @(posedge clk) begin
    rd_nl <= {13'd0, addr_nl[4:2]};
    rd_lp <= {13'd0, addr_lp[4:2]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles; sample/drive 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic found;
    rst_n = 1'b0;
    start_nl = 1'b0; stop_nl = 1'b0; ready_nl = 1'b1;
    start_lp = 1'b0; stop_lp = 1'b0; ready_lp = 1'b1;
    #12;
    // Reset state
    check("rst_addr_nl",  addr_nl, 32'h0);
    check("rst_valid_nl", {31'd0, valid_nl}, 32'd0);
    check("rst_busy_nl",  {31'd0, busy_nl}, 32'd0);
    check("rst_done_nl",  {31'd0, done_nl}, 32'd0);
    check("rst_ovr_nl",   {31'd0, ovr_nl}, 32'd0);
    check("rst_out_lp",   {16'd0, out_lp}, 32'd0);
    rst_n = 1'b1;
    step(1);

    // 1: LOOP=0 full clip, one sample per 4 cycles, first valid at start+6
    start_nl = 1'b1;
    step(1);
    start_nl = 1'b0;
    check("t1_busy", {31'd0, busy_nl}, 32'd1);
    step(4);
    check("t1_fetch_valid", {31'd0, valid_nl}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      step((k == 0) ? 1 : 4);
      check($sformatf("t1_valid_%0d", k), {31'd0, valid_nl}, 32'd1);
      check($sformatf("t1_sample_%0d", k), {16'd0, out_nl}, 32'(k));
      check($sformatf("t1_addr_%0d", k), addr_nl, (k == 7) ? 32'h1C : 32'(4 * (k + 1)));
    end
    check("t1_done", {31'd0, done_nl}, 32'd1);
    check("t1_busy_end", {31'd0, busy_nl}, 32'd0);
    step(1);
    check("t1_consumed", {31'd0, valid_nl}, 32'd0);

    // 2: LOOP=1, 20 ticks -> 0..7,0..7,0..3
    start_lp = 1'b1;
    step(1);
    start_lp = 1'b0;
    step(4);
    for (int k = 0; k < 20; k++) begin
      step((k == 0) ? 1 : 4);
      check($sformatf("t2_valid_%0d", k), {31'd0, valid_lp}, 32'd1);
      check($sformatf("t2_sample_%0d", k), {16'd0, out_lp}, 32'(k % 8));
      check($sformatf("t2_ovr_%0d", k), {31'd0, ovr_lp}, 32'd0);
    end
    check("t2_done", {31'd0, done_lp}, 32'd0);

    // 3: consumer stalls for 10 cycles after the first sample
    ready_nl = 1'b0;
    start_nl = 1'b1;
    step(1);
    start_nl = 1'b0;
    check("t3_done_clr", {31'd0, done_nl}, 32'd0);
    step(5);
    check("t3_first", {16'd0, out_nl}, 32'd0);
    step(3);
    check("t3_ovr", {31'd0, ovr_nl}, 32'd1);
    check("t3_hold_valid", {31'd0, valid_nl}, 32'd1);
    step(6);
    check("t3_hold_sample", {16'd0, out_nl}, 32'd0);
    check("t3_hold_addr", addr_nl, 32'h4);
    ready_nl = 1'b1;
    step(1);
    check("t3_drain", {31'd0, valid_nl}, 32'd0);
    step(2);
    check("t3_next_valid", {31'd0, valid_nl}, 32'd1);
    check("t3_next_sample", {16'd0, out_nl}, 32'd1);
    check("t3_next_addr", addr_nl, 32'h8);

    // 4: stop during FETCH
    step(3);
    check("t4_in_fetch", {31'd0, busy_nl}, 32'd1);
    stop_nl = 1'b1;
    step(1);
    stop_nl = 1'b0;
    check("t4_valid", {31'd0, valid_nl}, 32'd0);
    check("t4_busy", {31'd0, busy_nl}, 32'd0);
    check("t4_addr", addr_nl, 32'h0);
    start_nl = 1'b1;
    step(1);
    start_nl = 1'b0;
    check("t4_ovr_clr", {31'd0, ovr_nl}, 32'd0);
    step(5);
    check("t4_restart_valid", {31'd0, valid_nl}, 32'd1);
    check("t4_restart_sample", {16'd0, out_nl}, 32'd0);

    // 5: start and stop together from IDLE
    stop_nl = 1'b1;
    step(1);
    stop_nl = 1'b0;
    check("t5_idle", {31'd0, busy_nl}, 32'd0);
    start_nl = 1'b1;
    stop_nl  = 1'b1;
    step(1);
    start_nl = 1'b0;
    stop_nl  = 1'b0;
    check("t5_busy", {31'd0, busy_nl}, 32'd0);
    step(6);
    check("t5_no_sample", {31'd0, valid_nl}, 32'd0);
    check("t5_busy_late", {31'd0, busy_nl}, 32'd0);

    // 6: asynchronous reset mid-playback (LOOP=1 instance is still running)
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!found) begin
        step(1);
        if (valid_lp && (out_lp != 16'd0)) found = 1'b1;
      end
    end
    check("t6_setup", {31'd0, found}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid", {31'd0, valid_lp}, 32'd0);
    check("t6_sample", {16'd0, out_lp}, 32'd0);
    check("t6_addr", addr_lp, 32'h0);
    check("t6_busy", {31'd0, busy_lp}, 32'd0);
    check("t6_flags", {30'd0, done_lp, ovr_lp}, 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      check($sformatf("t6_quiet_%0d", i), {30'd0, valid_lp, busy_lp}, 32'd0);
    end
    start_lp = 1'b1;
    step(1);
    start_lp = 1'b0;
    step(5);
    check("t6_restart_valid", {31'd0, valid_lp}, 32'd1);
    check("t6_restart_sample", {16'd0, out_lp}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_sample_streamer.md
# rom_sample_streamer

Initiator for the single-port audio sample ROM: paces reads at the audio sample rate, issues word addresses, absorbs the ROM's one-cycle registered read latency, and presents each Q1.14 sample on a valid/ready stream to the downstream audio path (DSP or DAC serializer). It sits between the sample ROM and the audio consumer. It is the only block that drives the ROM address.

## Interface
Parameters:
- N_SAMPLES, 64000, number of samples in the ROM image (4 s clip; 112000 for the 7 s clip)
- SAMPLE_DIV, 3125, clk cycles per sample period (50 MHz / 16 kHz); must be ≥ 2
- LOOP, 1'b1, 1 = wrap to sample 0 after the last sample; 0 = stop

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse, begin playback from sample 0
- stop  in  1  single-cycle pulse, abort playback
- rom_addr  out  32  byte address to ROM, always {index, 2'b00} zero-extended
- rom_rd  in  16  ROM read data, valid one cycle after rom_addr is sampled
- sample_out  out  16  current sample, Q1.14 two's complement
- sample_valid  out  1  sample_out holds an unconsumed sample
- sample_ready  in  1  consumer accepts sample when high with sample_valid
- busy  out  1  high in WAIT_TICK and FETCH
- done  out  1  sticky, set on end of non-looping playback, cleared by start
- overrun  out  1  sticky, a sample tick was dropped, cleared by start

## Operation
- States: IDLE, WAIT_TICK, FETCH, DONE.
- IDLE: start → WAIT_TICK. Clear index, divider, done and overrun.
- Divider: counts 0..SAMPLE_DIV-1 in WAIT_TICK/FETCH and wraps. The tick is the cycle in which the count equals SAMPLE_DIV-1.
- WAIT_TICK with tick:
  - If the output slot is free (!sample_valid, or sample_valid && sample_ready in the same cycle) → FETCH.
  - Otherwise the tick is dropped, overrun ← 1, index unchanged, stay in WAIT_TICK.
- FETCH (one cycle): rom_rd holds rom[index].
  - At the end of the cycle: sample_out ← rom_rd, sample_valid ← 1.
  - If index == N_SAMPLES-1: LOOP=1 → index ← 0, go to WAIT_TICK; LOOP=0 → done ← 1, go to DONE.
  - Otherwise index ← index+1, go to WAIT_TICK.
- DONE: start → same entry as from IDLE. The last sample remains valid until it is consumed.
- Consumption: sample_valid && sample_ready clears sample_valid at the edge, unless FETCH reloads it in the same cycle, in which case it stays 1 with the new data.
- stop (any state except IDLE): → IDLE at the next edge. sample_valid ← 0 (pending sample discarded). index ← 0.
- start while busy: ignored. start and stop in the same cycle: stop wins.
- Width rules:
  - index is $clog2(N_SAMPLES) bits.
  - rom_addr[1:0] is always 0.
  - sample_out passes through unmodified; no arithmetic on the sample value.

## Timing
- Reset values: all outputs 0, rom_addr = 0, state IDLE, divider 0, index 0.
- rom_addr changes only at the end of FETCH or on start/stop, so it is stable for the ROM's sampling edge.
- Latency:
  - Tick cycle T, FETCH at T+1, sample_valid high at T+2.
  - First tick after start falls SAMPLE_DIV cycles after the start edge.
- Steady state: exactly one sample per SAMPLE_DIV cycles when the consumer keeps up.
- Reset asserted mid-playback: immediate return to reset values. No sample is emitted after rst_n is released until a new start.

## Structure
- Package audio_pkg holds:
  - sample_t (logic [15:0], Q1.14)
  - streamer state enum
  - constants N_SAMPLES_4S = 64000, N_SAMPLES_7S = 112000, SAMPLE_DIV_16K = 3125
- One natural sub-module: sample_tick_div (parameter DIV; inputs clk, rst_n, clear, en; output tick), instantiated once.
- FSM, index counter and output register live in the top module.

## Test plan
- ROM model with rom[i] = i; SAMPLE_DIV = 4, N_SAMPLES = 8, LOOP = 0, sample_ready = 1, start → samples 0..7 delivered one per 4 cycles, first valid at start+6, then done = 1, busy = 0, rom_addr = 0x1C.
- LOOP = 1, same setup, run 20 ticks → sequence 0..7,0..7,0..3, no overrun, done stays 0.
- sample_ready held low for 10 cycles after the first sample (SAMPLE_DIV = 4) → overrun = 1, sample_out holds 0, index not advanced; on release the next delivered sample is 1.
- stop asserted during FETCH → next cycle state IDLE, sample_valid = 0, rom_addr = 0; start then restarts from sample 0.
- start and stop pulsed in the same cycle from IDLE → block stays IDLE, busy = 0.
- rst_n pulled low mid-playback for 1 cycle, asynchronously between edges → all outputs 0 immediately; no further samples until start.
